pt_credit_tx: RTL and testbench
===============================

Name: pt_credit_tx

Overview:
- Credit-based transmitter that drives a downstream pt_fifo-style receiver across a registered, ready-less link.
- Accepts a valid/ready stream from local logic and forwards one beat per accepted transfer, registered.
- Holds one credit per free entry in the remote FIFO. Spends a credit per beat sent; regains one per credit-return pulse from the receiver's pop side.
- Provides a level-controlled drain for quiescing the link.

Parameters:
- DATA_T, logic [31:0], payload type.
- CREDITS, 8, initial credit count; equals remote FIFO DEPTH; must be >= 1.
- COUNT_W, $clog2(CREDITS+1), localparam; credit counter width.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_data  input  $bits(DATA_T)  upstream payload.
- i_valid  input  1  upstream valid.
- o_ready  output  1  upstream ready.
- o_data  output  $bits(DATA_T)  link payload, registered.
- o_valid  output  1  link valid, registered; no back-pressure on link.
- i_credit_return  input  1  one-cycle pulse per entry popped at the receiver.
- i_drain  input  1  level; request quiesce.
- o_drained  output  1  high in DRAINED state.
- o_credits  output  COUNT_W  current credit count (credits_q).
- o_error  output  1  sticky credit-overflow flag.

Behaviour:
- Reset (synchronous, i_rst high at a rising edge):
  - credits_q = CREDITS; state = ACTIVE; o_valid = 0; o_data = 0; o_error = 0.
  - Reset mid-transfer discards any in-flight beat. The receiver is reset together with this block.
- send = i_valid && o_ready.
- o_ready = (state == ACTIVE) && (credits_q != 0). It depends only on registered state; there is no combinational path from i_credit_return or i_valid to o_ready.
- Latency: an accepted beat appears on o_valid/o_data exactly 1 cycle later.
  - o_valid <= send.
  - o_data <= i_data when send; otherwise o_data holds its previous value.
- Back-to-back sends are allowed every cycle while credits remain.
- Credit update: credits_q <= credits_q - send + i_credit_return, computed at COUNT_W width.
  - Simultaneous send and return leaves the count unchanged.
  - At credits_q == 0, a return in the same cycle does not permit a send that cycle. The send becomes possible the next cycle.
- Overflow: i_credit_return while credits_q == CREDITS and !send.
  - Sets o_error; it stays set until reset.
  - credits_q saturates at CREDITS and never wraps.
- Underflow cannot occur, because o_ready is low at 0 credits.
- State machine, states ACTIVE, DRAINING, DRAINED:
  - ACTIVE -> DRAINING when i_drain = 1. o_ready is low from the next cycle. A send accepted in the same cycle i_drain rises still completes.
  - DRAINING -> DRAINED when credits_q == CREDITS and o_valid == 0.
  - DRAINING -> ACTIVE when i_drain = 0, even if credits are still outstanding.
  - DRAINED -> ACTIVE when i_drain = 0.
  - o_drained = (state == DRAINED), registered; it asserts the cycle after the DRAINING exit condition is met.
  - Credit returns are accepted in all states.
- CREDITS = 1: every send must wait for its return. Maximum throughput is one beat per round trip.

Test Plan:
- Reset, then i_valid held high with CREDITS=8 and no returns:
  - exactly 8 beats with data 0..7 appear on o_valid on cycles 1..8;
  - o_ready falls after the 8th accept; o_credits = 0.
- At o_credits = 0, pulse i_credit_return with i_valid high:
  - o_ready is low that cycle and high the next;
  - one beat is sent; o_credits returns to 0.
- Steady stream with i_credit_return high every cycle from credits_q = 4:
  - a beat is sent every cycle;
  - o_credits stays 4 throughout.
- Return pulse with o_credits = 8 and idle:
  - o_error rises next cycle and stays high;
  - o_credits stays 8.
- With 3 credits outstanding, raise i_drain:
  - o_ready goes low;
  - return 3 credits over 5 cycles; o_drained asserts the cycle after o_credits reaches 8;
  - drop i_drain: o_drained clears and o_ready goes high next cycle.
- Assert i_rst for one cycle during a stream with o_credits = 2:
  - next cycle o_valid = 0, o_credits = 8, o_error = 0, state ACTIVE.

Source files
------------

// File: rtl/pt_credit_tx.sv
// Credit-based link transmitter: forwards accepted upstream beats one cycle later
// while tracking free entries in the remote receiver FIFO, with a level-driven drain.
module pt_credit_tx #(
  parameter type DATA_T  = logic [31:0],
  parameter int  CREDITS = 8,
  localparam int COUNT_W = $clog2(CREDITS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  DATA_T              i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output DATA_T              o_data,
  output logic               o_valid,
  input  logic               i_credit_return,
  input  logic               i_drain,
  output logic               o_drained,
  output logic [COUNT_W-1:0] o_credits,
  output logic               o_error
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAINING,
    ST_DRAINED
  } state_e;

  localparam logic [COUNT_W-1:0] FullCount = COUNT_W'(CREDITS);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] credits_q, credits_d;
  logic               valid_q, valid_d;
  DATA_T              data_q, data_d;
  logic               error_q, error_d;
  logic               send;

  // Ready comes only from registered state, so a same-cycle credit return cannot unblock a send.
  assign o_ready = (state_q == ST_ACTIVE) && (credits_q != '0);
  assign send    = i_valid && o_ready;

  always_comb begin
    credits_d = credits_q;
    error_d   = error_q;
    valid_d   = send;
    data_d    = send ? i_data : data_q;
    state_d   = state_q;

    if (send && !i_credit_return) begin
      credits_d = credits_q - COUNT_W'(1);
    end else if (!send && i_credit_return) begin
      if (credits_q == FullCount) begin
        error_d = 1'b1;
      end else begin
        credits_d = credits_q + COUNT_W'(1);
      end
    end

    // Draining completes once every credit is home and no beat is still on the wire.
    unique case (state_q)
      ST_ACTIVE: begin
        if (i_drain) state_d = ST_DRAINING;
      end
      ST_DRAINING: begin
        if (!i_drain) begin
          state_d = ST_ACTIVE;
        end else if (credits_q == FullCount && !valid_q) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!i_drain) state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_ACTIVE;
      credits_q <= FullCount;
      valid_q   <= 1'b0;
      data_q    <= DATA_T'('0);
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      error_q   <= error_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_credits = credits_q;
  assign o_error   = error_q;
  assign o_drained = (state_q == ST_DRAINED);

endmodule

// File: tb/tb_pt_credit_tx.sv
// Randomised scoreboard bench for pt_credit_tx: a credit-ledger model predicts
// each cycle's ready/credits/error/drained state and the beats expected on the link.
module tb_pt_credit_tx;

  localparam int CREDITS = 8;
  localparam int COUNT_W = $clog2(CREDITS + 1);
  localparam int MODE_RUN      = 0;
  localparam int MODE_DRAINING = 1;
  localparam int MODE_DRAINED  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        inData;
  logic               inValid;
  logic               outReady;
  logic [31:0]        outData;
  logic               outValid;
  logic               creditReturn;
  logic               drain;
  logic               drained;
  logic [COUNT_W-1:0] credits;
  logic               error;

  always #5 clk = ~clk;

  pt_credit_tx #(.CREDITS(CREDITS)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_data          (inData),
    .i_valid         (inValid),
    .o_ready         (outReady),
    .o_data          (outData),
    .o_valid         (outValid),
    .i_credit_return (creditReturn),
    .i_drain         (drain),
    .o_drained       (drained),
    .o_credits       (credits),
    .o_error         (error)
  );

  int          mdlCredits;
  bit          mdlErr;
  int          mdlMode;
  bit          mdlValid;
  logic [31:0] expQ[$];
  bit          checkEn = 1'b0;
  int          passCount = 0;
  int          checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ledger view: free remote slots = credits; a beat leaves only when the link is open
  // and a slot is free; returns beyond the FIFO depth are overflow and are clipped.
  task automatic modelStep();
    int  oldCredits;
    bit  oldOnWire;
    bit  accepted;
    if (rst) begin
      mdlCredits = CREDITS;
      mdlErr     = 1'b0;
      mdlMode    = MODE_RUN;
      mdlValid   = 1'b0;
      expQ.delete();
      checkEn    = 1'b1;
      return;
    end
    oldCredits = mdlCredits;
    oldOnWire  = mdlValid;
    accepted   = inValid && (mdlMode == MODE_RUN) && (mdlCredits > 0);
    if (accepted) expQ.push_back(inData);
    mdlValid   = accepted;
    mdlCredits = mdlCredits - (accepted ? 1 : 0) + (creditReturn ? 1 : 0);
    if (mdlCredits > CREDITS) begin
      mdlCredits = CREDITS;
      mdlErr     = 1'b1;
    end
    if (!drain) mdlMode = MODE_RUN;
    else if (mdlMode == MODE_RUN) mdlMode = MODE_DRAINING;
    else if (mdlMode == MODE_DRAINING && oldCredits == CREDITS && !oldOnWire) mdlMode = MODE_DRAINED;
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit ret,
                               input bit dr, input bit r);
    inValid      = v;
    inData       = d;
    creditReturn = ret;
    drain        = dr;
    rst          = r;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  // Monitor: compares the DUT's visible state and pops the scoreboard on each link beat.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ready", 32'(outReady), 32'((mdlMode == MODE_RUN) && (mdlCredits > 0)));
      checkOutput("credits", 32'(credits), 32'(mdlCredits));
      checkOutput("error", 32'(error), 32'(mdlErr));
      checkOutput("drained", 32'(drained), 32'(mdlMode == MODE_DRAINED));
      checkOutput("valid", 32'(outValid), 32'(mdlValid));
      if (outValid) begin
        if (expQ.size() == 0) checkOutput("beat expected", 32'(1), 32'(0));
        else checkOutput("data", outData, expQ.pop_front());
      end else if (mdlValid && expQ.size() != 0) begin
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Stream into a full credit pool: eight beats 0..7 then stall at zero credits.
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i), 0, 0, 0);

    // Return at zero credits: blocked that cycle, one beat the next.
    applyStimulus(1, $urandom, 1, 0, 0);
    applyStimulus(1, $urandom, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Bring the pool to four, then stream with a return every cycle.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, $urandom, 1, 0, 0);

    // Refill, then an idle return at full pool overflows.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

    // Three credits outstanding, drain, trickle the returns back, release.
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, $urandom, (i % 2) == 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom, 0, 0, 0);

    // Refill, stream down to two credits, then reset mid-stream.
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, $urandom, 0, 0, 0);
    applyStimulus(1, $urandom, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom, 0, 0, 0);

    // Random traffic with occasional drain toggles and resets.
    begin
      bit dr = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 39) == 0) dr = ~dr;
        applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                      dr, $urandom_range(0, 249) == 0);
      end
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
